mips_mc_ctrl: RTL and testbench

Multi-cycle control sequencer for the MIPS datapath. It accepts one instruction word at a time through a valid/ready handshake and decodes it. It then walks the registered ALU and the memory/register-file stages through a fixed state sequence, driving the ALU operand-select, operation and enable lines, plus the memory and write-back strobes. It sits between instruction memory and the datapath and replaces per-instruction combinational control.

---
 rtl/mips_ctrl_pkg.sv | 32 +++
 rtl/mips_decode.sv | 48 ++++
 rtl/mips_mc_ctrl.sv | 82 ++++++++
 tb/tb_mips_mc_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multi-cycle MIPS control sequencer
//   state_e   : sequencer states
//   OP_*/FN_* : supported opcode and R-type funct values
//   alu_op_e  : ALU operation select, pc_src_e : PC source select
//   ctrl_t    : decoded control word registered by the sequencer in DECODE
package mips_ctrl_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_ALU_WAIT, S_MEM, S_WB} state_e;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  typedef enum logic [2:0] {ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011, ALU_SLT = 3'b100} alu_op_e;
  typedef enum logic [1:0] {PC_4 = 2'b00, PC_BRANCH = 2'b01, PC_JUMP = 2'b10} pc_src_e;
  typedef struct packed {
    logic    alu_src_imm;
    alu_op_e alu_op;
    logic    reg_dst;
    logic    mem_to_reg;
    logic    is_load;
    logic    is_store;
    logic    is_branch;
    logic    is_jump;
    logic    illegal;
  } ctrl_t;
endpackage

// File: rtl/mips_decode.sv
// mips_decode: combinational instruction decoder, IR -> control word
//   ir_i   : instruction register
//   ctrl_o : decoded control word; unsupported opcode/funct sets illegal
module mips_decode
  import mips_ctrl_pkg::*;
(
  input  logic [31:0] ir_i,
  output ctrl_t       ctrl_o
);
  logic [5:0] op, fn;
  logic unused_ir;
  assign op = ir_i[31:26];
  assign fn = ir_i[5:0];
  assign unused_ir = ^ir_i[25:6];
  always_comb begin
    ctrl_o = '0;
    ctrl_o.alu_op = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        ctrl_o.reg_dst = 1'b1;
        case (fn)
          FN_ADD:  ctrl_o.alu_op = ALU_ADD;
          FN_SUB:  ctrl_o.alu_op = ALU_SUB;
          FN_AND:  ctrl_o.alu_op = ALU_AND;
          FN_OR:   ctrl_o.alu_op = ALU_OR;
          FN_SLT:  ctrl_o.alu_op = ALU_SLT;
          default: ctrl_o.illegal = 1'b1;
        endcase
      end
      OP_LW: begin
        ctrl_o.alu_src_imm = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.is_load = 1'b1;
      end
      OP_SW: begin
        ctrl_o.alu_src_imm = 1'b1;
        ctrl_o.is_store = 1'b1;
      end
      OP_ADDI: ctrl_o.alu_src_imm = 1'b1;
      OP_BEQ: begin
        ctrl_o.alu_op = ALU_SUB;
        ctrl_o.is_branch = 1'b1;
      end
      OP_J:    ctrl_o.is_jump = 1'b1;
      default: ctrl_o.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle control sequencer for the MIPS datapath
//   clk, rst (sync, active-low)
//   instr_valid/instr/instr_ready : instruction handshake, accepted only in FETCH
//   alu_zero                      : ALU zero flag, sampled in ALU_WAIT for beq
//   alu_en/alu_src_imm/alu_op     : ALU control
//   reg_dst/reg_write/mem_to_reg  : write-back control
//   mem_read/mem_write            : data-memory strobes
//   pc_write/pc_src               : PC update control
//   busy/illegal                  : status
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        alu_zero,
  output logic        alu_en,
  output logic        alu_src_imm,
  output logic [2:0]  alu_op,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        mem_read,
  output logic        mem_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        busy,
  output logic        illegal
);
  state_e state_q, state_d;
  logic [31:0] ir_q;
  ctrl_t ctrl_q, dec;
  logic in_dec, in_alu, br_taken;
  mips_decode u_decode (.ir_i(ir_q), .ctrl_o(dec));
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      ir_q <= '0;
      ctrl_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && instr_valid) ir_q <= instr;
      if (state_q == S_DECODE) ctrl_q <= dec;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = instr_valid ? S_DECODE : S_FETCH;
      S_DECODE:   state_d = (dec.is_jump || dec.illegal) ? S_FETCH : S_EXEC;
      S_EXEC:     state_d = S_ALU_WAIT;
      S_ALU_WAIT: state_d = ctrl_q.is_branch ? S_FETCH : (ctrl_q.is_load || ctrl_q.is_store) ? S_MEM : S_WB;
      S_MEM:      state_d = ctrl_q.is_load ? S_WB : S_FETCH;
      S_WB:       state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end
  // Outputs are gated by rst so nothing leaks out while reset is asserted,
  // even before the state register has been forced back to FETCH.
  // During DECODE the ALU controls come straight from the decoder so they
  // are already stable in the cycle before EXEC enables the ALU.
  always_comb begin
    in_dec = state_q == S_DECODE;
    in_alu = state_q == S_EXEC || state_q == S_ALU_WAIT;
    br_taken = state_q == S_ALU_WAIT && ctrl_q.is_branch && alu_zero;
    instr_ready = rst && state_q == S_FETCH;
    busy = rst && state_q != S_FETCH;
    alu_en = rst && state_q == S_EXEC;
    alu_src_imm = rst && (in_dec ? dec.alu_src_imm : in_alu && ctrl_q.alu_src_imm);
    alu_op = !rst ? ALU_ADD : in_dec ? dec.alu_op : in_alu ? ctrl_q.alu_op : ALU_ADD;
    reg_write = rst && state_q == S_WB;
    reg_dst = rst && state_q == S_WB && ctrl_q.reg_dst;
    mem_to_reg = rst && state_q == S_WB && ctrl_q.mem_to_reg;
    mem_read = rst && state_q == S_MEM && ctrl_q.is_load;
    mem_write = rst && state_q == S_MEM && ctrl_q.is_store;
    pc_write = rst && (in_dec || br_taken);
    pc_src = !rst ? PC_4 : (in_dec && dec.is_jump) ? PC_JUMP : br_taken ? PC_BRANCH : PC_4;
    illegal = rst && in_dec && dec.illegal;
  end
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: scoreboard bench for mips_mc_ctrl
module tb_mips_mc_ctrl;
  typedef struct packed {
    logic rdy, busy, alu_en, imm;
    logic [2:0] op;
    logic rdst, rw, m2r, mr, mw, pcw;
    logic [1:0] pcs;
    logic ill;
  } ov_t;
  logic clk = 0, rst = 0, instr_valid = 0, alu_zero = 0;
  logic [31:0] instr = '0;
  logic instr_ready, alu_en, alu_src_imm, reg_dst, reg_write, mem_to_reg, mem_read, mem_write, pc_write, busy, illegal;
  logic [2:0] alu_op;
  logic [1:0] pc_src;
  ov_t obs, rdy_v;
  ov_t q[$];
  int n_chk = 0, n_err = 0;
  mips_mc_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .alu_zero(alu_zero), .alu_en(alu_en), .alu_src_imm(alu_src_imm), .alu_op(alu_op),
    .reg_dst(reg_dst), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
    .mem_write(mem_write), .pc_write(pc_write), .pc_src(pc_src), .busy(busy), .illegal(illegal)
  );
  assign obs = {instr_ready, busy, alu_en, alu_src_imm, alu_op, reg_dst, reg_write, mem_to_reg, mem_read, mem_write, pc_write, pc_src, illegal};
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
  task automatic chk(input string tag, input ov_t got, input ov_t exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
    end
  endtask
  function automatic void push_instr(input logic [31:0] w, input logic z);
    logic [5:0] op = w[31:26];
    logic [5:0] fn = w[5:0];
    logic rt = op == 6'h00, j = op == 6'h02, lw = op == 6'h23, sw = op == 6'h2b, beq = op == 6'h04, addi = op == 6'h08;
    logic legal = 1'b1, ill, imm;
    logic [2:0] aop = 3'd0;
    ov_t b;
    if (rt)
      case (fn)
        6'h20: aop = 3'd0;
        6'h22: aop = 3'd1;
        6'h24: aop = 3'd2;
        6'h25: aop = 3'd3;
        6'h2a: aop = 3'd4;
        default: legal = 1'b0;
      endcase
    if (beq) aop = 3'd1;
    ill = rt ? !legal : !(j || lw || sw || beq || addi);
    imm = lw || sw || addi;
    b = '0; b.busy = 1; b.pcw = 1; b.pcs = j ? 2'd2 : 2'd0; b.ill = ill;
    b.op = (j || ill) ? 3'd0 : aop; b.imm = imm;
    q.push_back(b);
    if (j || ill) begin
      q.push_back(rdy_v);
      return;
    end
    b = '0; b.busy = 1; b.alu_en = 1; b.op = aop; b.imm = imm;
    q.push_back(b);
    b.alu_en = 0;
    if (beq && z) begin b.pcw = 1; b.pcs = 2'd1; end
    q.push_back(b);
    if (beq) begin
      q.push_back(rdy_v);
      return;
    end
    b = '0; b.busy = 1; b.mr = lw; b.mw = sw; b.rw = !(lw || sw); b.rdst = rt;
    q.push_back(b);
    if (lw) begin
      b = '0; b.busy = 1; b.rw = 1; b.m2r = 1;
      q.push_back(b);
    end
    q.push_back(rdy_v);
  endfunction
  // Drives one instruction; outside FETCH instr_valid toggles with junk
  // words, which the controller must ignore.
  task automatic run(input logic [31:0] w, input logic z, input string tag);
    int c = 0;
    instr = w; instr_valid = 1; alu_zero = z;
    push_instr(w, z);
    while (q.size() > 0) begin
      @(posedge clk); #1;
      c++;
      instr_valid = q.size() > 1 ? 1'($urandom_range(0, 1)) : 1'b0;
      instr = $urandom;
      chk($sformatf("%s_c%0d", tag, c), obs, q.pop_front());
    end
  endtask
  initial begin
    rdy_v = '0; rdy_v.rdy = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", obs, '0);
    rst = 1;
    #1;
    chk("rst_rel", obs, rdy_v);
    run(32'h012A4020, 1'b0, "add");
    run(32'h012A4022, 1'b1, "sub");
    run(32'h012A4024, 1'b0, "and");
    run(32'h012A4025, 1'b0, "or");
    run(32'h012A402A, 1'b0, "slt");
    run(32'h21090005, 1'b1, "addi");
    run(32'h8D090004, 1'b0, "lw");
    run(32'hAD090008, 1'b1, "sw");
    run(32'h11090003, 1'b1, "beq_t");
    run(32'h11090003, 1'b0, "beq_n");
    run(32'h08000010, 1'b0, "j");
    run(32'hFC000000, 1'b0, "ill_op");
    run(32'h012A4007, 1'b0, "ill_fn");
    run(32'hAD090008, 1'b0, "sw_b2b");
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle", obs, rdy_v);
    end
    instr = 32'h8D090004; instr_valid = 1;
    push_instr(instr, 1'b0);
    for (int i = 1; i <= 2; i++) begin
      @(posedge clk); #1;
      instr_valid = 0;
      chk($sformatf("lw_rst_c%0d", i), obs, q.pop_front());
    end
    q.delete();
    rst = 0;
    #1;
    chk("mid_rst_now", obs, '0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("mid_rst_%0d", i), obs, '0);
    end
    rst = 1;
    #1;
    chk("mid_rst_rel", obs, rdy_v);
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst", obs, rdy_v);
    end
    run(32'h012A4020, 1'b0, "add_after_rst");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
